// File: rtl/mem_port_arb.sv
// Two-master (instruction/data) arbiter onto one pipelined memory port with an owner FIFO for in-order responses.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin on contention; otherwise data has fixed priority.
module mem_port_arb #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             owner_fifo [MAX_OUTSTANDING];
    logic             sel_valid;
    logic             sel_d;
    logic             fifo_full;
    logic             head_d;
    logic             push;
    logic             pop;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_d;
`endif

    assign fifo_full = (count == MAX_CNT);
    assign head_d    = owner_fifo[rd_ptr];

    // A locked owner keeps the port until granted, even if its request drops.
    always_comb begin
        sel_valid  = 1'b0;
        sel_d      = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!fifo_full) begin
                    if (instr_req_i && data_req_i) begin
                        sel_valid = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        sel_d     = ~last_d;
`else
                        sel_d     = 1'b1;
`endif
                    end else if (data_req_i) begin
                        sel_valid = 1'b1;
                        sel_d     = 1'b1;
                    end else if (instr_req_i) begin
                        sel_valid = 1'b1;
                        sel_d     = 1'b0;
                    end
                end
                if (sel_valid && !mem_gnt_i) begin
                    state_next = sel_d ? LOCK_D : LOCK_I;
                end
            end
            LOCK_I: begin
                sel_valid = 1'b1;
                sel_d     = 1'b0;
                if (mem_gnt_i) begin
                    state_next = IDLE;
                end
            end
            LOCK_D: begin
                sel_valid = 1'b1;
                sel_d     = 1'b1;
                if (mem_gnt_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign mem_req_o   = sel_valid;
    assign mem_we_o    = sel_valid & sel_d & data_we_i;
    assign mem_be_o    = !sel_valid ? 4'h0 : (sel_d ? data_be_i : 4'hF);
    assign mem_addr_o  = !sel_valid ? 32'h0 : (sel_d ? data_addr_i : instr_addr_i);
    assign mem_wdata_o = (sel_valid && sel_d) ? data_wdata_i : 32'h0;

    assign push        = sel_valid & mem_gnt_i;
    assign pop         = mem_rvalid_i & (count != '0);

    assign instr_gnt_o    = push & ~sel_d;
    assign data_gnt_o     = push & sel_d;
    assign instr_rvalid_o = pop & ~head_d;
    assign data_rvalid_o  = pop & head_d;
    assign rsp_rdata_o    = mem_rdata_i;
    assign rsp_err_o      = mem_err_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (push) begin
                last_d <= sel_d;
            end
`endif
        end
    end

    // Owner slots carry no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            owner_fifo[wr_ptr] <= sel_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: queue-based reference model checked every cycle plus literal spot checks.
module tb_mem_port_arb;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_req_i = 1'b0;
    logic [31:0] instr_addr_i = '0;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic        data_req_i = 1'b0;
    logic        data_we_i = 1'b0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_addr_i = '0;
    logic [31:0] data_wdata_i = '0;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_err_i = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference model: queue of outstanding owners (0=I, 1=D), pending locked owner, last granted owner.
    int owner_q[$];
    int pending = -1;
    int last_owner = 0;

    mem_port_arb #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
    );

    always #5 clk = ~clk;

    function automatic int model_owner();
        if (pending >= 0) return pending;
        if (owner_q.size() >= MAXO) return -1;
        if (instr_req_i && data_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            return (last_owner == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        if (data_req_i) return 1;
        if (instr_req_i) return 0;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model (inputs settle at posedge+1, compared at negedge).
    always @(negedge clk) begin
        if (!rst) begin
            int own;
            logic [31:0] e_addr, e_wdata;
            logic [3:0]  e_be;
            logic        e_we, e_irv, e_drv;
            own     = model_owner();
            e_addr  = (own == 1) ? data_addr_i : (own == 0) ? instr_addr_i : 32'h0;
            e_wdata = (own == 1) ? data_wdata_i : 32'h0;
            e_be    = (own == 1) ? data_be_i : (own == 0) ? 4'hF : 4'h0;
            e_we    = (own == 1) && data_we_i;
            e_irv   = mem_rvalid_i && owner_q.size() > 0 && owner_q[0] == 0;
            e_drv   = mem_rvalid_i && owner_q.size() > 0 && owner_q[0] == 1;
            checkOutput("mem_req",  {31'h0, mem_req_o},  {31'h0, own >= 0});
            checkOutput("mem_addr", mem_addr_o, e_addr);
            checkOutput("mem_wdata", mem_wdata_o, e_wdata);
            checkOutput("mem_be",   {28'h0, mem_be_o}, {28'h0, e_be});
            checkOutput("mem_we",   {31'h0, mem_we_o}, {31'h0, e_we});
            checkOutput("instr_gnt", {31'h0, instr_gnt_o}, {31'h0, own == 0 && mem_gnt_i});
            checkOutput("data_gnt",  {31'h0, data_gnt_o},  {31'h0, own == 1 && mem_gnt_i});
            checkOutput("instr_rvalid", {31'h0, instr_rvalid_o}, {31'h0, e_irv});
            checkOutput("data_rvalid",  {31'h0, data_rvalid_o},  {31'h0, e_drv});
            checkOutput("rsp_rdata", rsp_rdata_o, mem_rdata_i);
            checkOutput("rsp_err",   {31'h0, rsp_err_o}, {31'h0, mem_err_i});
        end
    end

    // Model state advance on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            owner_q.delete();
            pending    = -1;
            last_owner = 0;
        end else begin
            int own;
            own = model_owner();
            if (mem_rvalid_i && owner_q.size() > 0) void'(owner_q.pop_front());
            if (own >= 0 && mem_gnt_i) begin
                owner_q.push_back(own);
                last_owner = own;
                pending    = -1;
            end else begin
                pending = own;
            end
        end
    end

    task automatic applyStimulus(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [3:0] dbe,
        input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic gnt, input logic rv, input logic [31:0] rdata, input logic err);
        @(posedge clk);
        #1;
        instr_req_i  = ireq;  instr_addr_i = iaddr;
        data_req_i   = dreq;  data_we_i    = dwe;   data_be_i = dbe;
        data_addr_i  = daddr; data_wdata_i = dwdata;
        mem_gnt_i    = gnt;   mem_rvalid_i = rv;
        mem_rdata_i  = rdata; mem_err_i    = err;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic exp_d [4];
        // Reset: nothing selected, stray rvalid ignored.
        rst = 1'b1;
        idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0);
        checkOutput("reset_mem_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("reset_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        rst = 1'b0;

        // Single instruction fetch then response.
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checkOutput("fetch_addr", mem_addr_o, 32'h100);
        checkOutput("fetch_be", {28'h0, mem_be_o}, 32'hF);
        checkOutput("fetch_gnt", {31'h0, instr_gnt_o}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h13, 0);
        checkOutput("fetch_rvalid", {31'h0, instr_rvalid_o}, 32'h1);
        checkOutput("fetch_rdata", rsp_rdata_o, 32'h13);
        idleCycle();

        // Contention for four granted cycles; responses keep the FIFO from filling.
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h200, 1, 0, 4'h3, 32'h300, 32'h55, 1, k != 0, 32'h0, 0);
            checkOutput($sformatf("contend_dgnt%0d", k), {31'h0, data_gnt_o}, {31'h0, exp_d[k]});
            checkOutput($sformatf("contend_ignt%0d", k), {31'h0, instr_gnt_o}, {31'h0, ~exp_d[k]});
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idleCycle();

        // Stalled instruction request locks the port while data rises.
        applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 32'h200, 1, 0, 4'hF, 32'h300, 0, 0, 0, 0, 0);
            checkOutput("lock_addr", mem_addr_o, 32'h200);
            checkOutput("lock_dgnt", {31'h0, data_gnt_o}, 32'h0);
        end
        applyStimulus(1, 32'h200, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0, 0);
        checkOutput("lock_ignt", {31'h0, instr_gnt_o}, 32'h1);
        checkOutput("lock_dgnt_rel", {31'h0, data_gnt_o}, 32'h0);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h300, 0, 1, 0, 0, 0);
        checkOutput("after_lock_dgnt", {31'h0, data_gnt_o}, 32'h1);
        checkOutput("after_lock_addr", mem_addr_o, 32'h300);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 0);
        checkOutput("lock_rsp_i", {31'h0, instr_rvalid_o}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h2, 0);
        checkOutput("lock_rsp_d", {31'h0, data_rvalid_o}, 32'h1);

        // Outstanding limit: two writes granted, third blocked until a response drains.
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h400, 32'hDEADBEEF, 1, 0, 0, 0);
        checkOutput("wr_we", {31'h0, mem_we_o}, 32'h1);
        checkOutput("wr_be", {28'h0, mem_be_o}, 32'h3);
        checkOutput("wr_wdata", mem_wdata_o, 32'hDEADBEEF);
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h404, 32'h1234, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h408, 32'h5678, 1, 0, 0, 0);
        checkOutput("full_block_req", {31'h0, mem_req_o}, 32'h0);
        checkOutput("full_block_gnt", {31'h0, data_gnt_o}, 32'h0);
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h408, 32'h5678, 1, 1, 0, 0);
        checkOutput("full_no_bypass", {31'h0, mem_req_o}, 32'h0);
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h408, 32'h5678, 1, 0, 0, 0);
        checkOutput("full_reissue", {31'h0, data_gnt_o}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Interleaved grants, error on second response, then a stray response.
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h600, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hAAAA, 0);
        checkOutput("il_irv", {31'h0, instr_rvalid_o}, 32'h1);
        checkOutput("il_err0", {31'h0, rsp_err_o}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55, 1);
        checkOutput("il_drv", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h1);
        checkOutput("il_err1", {31'h0, rsp_err_o}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0);
        checkOutput("stray_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);

        // Reset mid-transaction discards ownership.
        applyStimulus(1, 32'h700, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst = 1'b1;
        idleCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11, 0);
        checkOutput("post_reset_rvalid", {30'h0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        idleCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
